// File: rtl/mimo_chk_pkg.sv
// Shared types and width helpers for the MIMO bit-error monitor.
// Widths are computed from the run parameters so that counters cannot overflow within a run.
package mimo_chk_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} mon_state_e;

  localparam int DEF_BITS_PER_SYM = 4;

  function automatic int aw_f(input int num_sym);
    return $clog2(num_sym);
  endfunction

  function automatic int cw_f(input int num_ch);
    return $clog2(num_ch);
  endfunction

  function automatic int pcw_f(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic int ecw_f(input int bps, input int num_sym);
    return $clog2(bps * num_sym + 1);
  endfunction

  function automatic int etw_f(input int num_ch, input int bps, input int num_sym);
    return $clog2(num_ch * bps * num_sym + 1);
  endfunction
endpackage

// File: rtl/bit_err_popcount.sv
// Registered XOR + popcount of two W-bit vectors.
module bit_err_popcount import mimo_chk_pkg::*; #(
  parameter  int W  = 4,
  localparam int PW = pcw_f(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [PW-1:0] cnt
);
  logic [PW-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    for (int k = 0; k < W; k++) cnt_d = cnt_d + PW'(a[k] ^ b[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_d;
  end
endmodule

// File: rtl/mimo_ber_monitor.sv
// Per-channel bit-error monitor: compares the live receiver symbol stream against a
// preloaded reference and accumulates error counts over a run of NUM_SYM symbols.
module mimo_ber_monitor import mimo_chk_pkg::*; #(
  parameter  int NUM_CH       = 3,
  parameter  int BITS_PER_SYM = DEF_BITS_PER_SYM,
  parameter  int NUM_SYM      = 128,
  localparam int AW  = aw_f(NUM_SYM),
  localparam int CW  = cw_f(NUM_CH),
  localparam int ECW = ecw_f(BITS_PER_SYM, NUM_SYM),
  localparam int ETW = etw_f(NUM_CH, BITS_PER_SYM, NUM_SYM)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           ref_valid,
  input  logic [CW-1:0]                  ref_ch,
  input  logic [AW-1:0]                  ref_addr,
  input  logic [BITS_PER_SYM-1:0]        ref_bits,
  input  logic                           output_valid,
  input  logic [NUM_CH*BITS_PER_SYM-1:0] output_num,
  output logic                           busy,
  output logic                           done,
  output logic [AW:0]                    sym_count,
  output logic [15:0]                    extra_count,
  output logic [NUM_CH*ECW-1:0]          err_count,
  output logic [ETW-1:0]                 err_total,
  output logic                           mismatch_valid,
  output logic [NUM_CH-1:0]              mismatch_mask
);
  localparam int          PW       = pcw_f(BITS_PER_SYM);
  localparam logic [AW:0] LAST_SYM = (AW+1)'(NUM_SYM - 1);

  mon_state_e state_q, state_d;

  logic [BITS_PER_SYM-1:0]                  mem [NUM_CH][NUM_SYM];
  logic [NUM_CH-1:0][BITS_PER_SYM-1:0]      exp_q, rcv_q;
  logic [NUM_CH-1:0][PW-1:0]                pc;
  logic [NUM_CH-1:0][ECW-1:0]               err_q;
  logic [NUM_CH-1:0]                        mask_d;
  logic [ETW-1:0]                           sum_d;
  // [0]: read stage, [1]: popcount stage, [2]: result presented
  logic [2:0]                               vld_pipe;
  logic                                     accept, wr_en, extra_inc;

  assign wr_en     = ref_valid && (state_q == IDLE || state_q == DONE);
  assign accept    = output_valid && !start && state_q == RUN && sym_count <= LAST_SYM;
  assign extra_inc = output_valid && !start && (state_q == DRAIN || state_q == DONE);

  assign busy           = (state_q == RUN) || (state_q == DRAIN);
  assign mismatch_valid = vld_pipe[2];
  assign err_count      = err_q;

  // Reference memory is deliberately left out of reset so a reload is not needed after rst.
  always_ff @(posedge clk) begin
    if (wr_en)
      for (int c = 0; c < NUM_CH; c++)
        if (ref_ch == CW'(c)) mem[c][ref_addr] <= ref_bits;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= '0;
      rcv_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) exp_q[c] <= mem[c][sym_count[AW-1:0]];
      rcv_q <= output_num;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    bit_err_popcount #(.W(BITS_PER_SYM)) u_pc (
      .clk (clk),
      .rst (rst),
      .a   (exp_q[c]),
      .b   (rcv_q[c]),
      .cnt (pc[c])
    );
  end

  always_comb begin
    sum_d  = '0;
    mask_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sum_d     = sum_d + ETW'(pc[c]);
      mask_d[c] = |pc[c];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (start) state_d = RUN;
               else if (accept && sym_count == LAST_SYM) state_d = DRAIN;
      // Last result is in the popcount stage and nothing follows it.
      DRAIN:   if (start) state_d = RUN;
               else if (vld_pipe[1] && !vld_pipe[0]) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      done          <= 1'b0;
      sym_count     <= '0;
      extra_count   <= '0;
      err_q         <= '0;
      err_total     <= '0;
      vld_pipe      <= '0;
      mismatch_mask <= '0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == DRAIN) && (state_d == DONE);
      if (start) begin
        sym_count     <= '0;
        extra_count   <= '0;
        err_q         <= '0;
        err_total     <= '0;
        vld_pipe      <= '0;
        mismatch_mask <= '0;
      end else begin
        vld_pipe      <= {vld_pipe[1:0], accept};
        mismatch_mask <= vld_pipe[1] ? mask_d : '0;
        if (accept) sym_count <= sym_count + 1'b1;
        if (extra_inc && extra_count != '1) extra_count <= extra_count + 1'b1;
        if (vld_pipe[1]) begin
          for (int c = 0; c < NUM_CH; c++) err_q[c] <= err_q[c] + ECW'(pc[c]);
          err_total <= err_total + sum_d;
        end
      end
    end
  end
endmodule
